// File: rtl/shift_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_universal
//  Purpose  : Parametrised universal shift register (hold / shift-left /
//             shift-right / parallel load) with a serial output for chaining
//             and a bit counter that pulses word_valid on every completed
//             serial word of WIDTH bits.
//  Ports    : clk        - rising-edge clock
//             reset      - asynchronous active-high reset, clears all state
//             en         - clock enable; 0 holds everything (acts as mode 00)
//             mode[1:0]  - 00 hold, 01 shift left, 10 shift right, 11 load
//             sdi        - serial data in
//             d          - parallel load data
//             q          - register contents (registered)
//             sdo        - next bit to be shifted out (combinational)
//             bit_cnt    - serial bits accepted in the current word
//             word_valid - one-cycle pulse: q holds a complete serial word
//  Revision : 1.0 - initial release
// ============================================================================
module shift_reg_universal #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sdi,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sdo,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_valid
);

  localparam logic [1:0]       MODE_HOLD  = 2'b00;
  localparam logic [1:0]       MODE_LEFT  = 2'b01;
  localparam logic [1:0]       MODE_RIGHT = 2'b10;
  localparam logic [1:0]       MODE_LOAD  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q,          q_d;
  logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
  logic             word_valid_q, word_valid_d;
  logic             shift_act;

  always_comb begin
    q_d          = q_q;
    bit_cnt_d    = bit_cnt_q;
    word_valid_d = 1'b0;      // pulse only; every non-completing cycle clears it
    shift_act    = 1'b0;

    if (en) begin
      case (mode)
        MODE_LEFT: begin
          q_d       = {q_q[WIDTH-2:0], sdi};
          shift_act = 1'b1;
        end
        MODE_RIGHT: begin
          q_d       = {sdi, q_q[WIDTH-1:1]};
          shift_act = 1'b1;
        end
        MODE_LOAD: begin
          // A load discards any partially received serial word.
          q_d       = d;
          bit_cnt_d = '0;
        end
        default: ; // MODE_HOLD
      endcase
    end

    // Both shift directions advance the same word counter; it wraps
    // straight into the next word so back-to-back words need no idle cycle.
    if (shift_act) begin
      if (bit_cnt_q == CNT_LAST) begin
        bit_cnt_d    = '0;
        word_valid_d = 1'b1;
      end else begin
        bit_cnt_d    = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q          <= '0;
      bit_cnt_q    <= '0;
      word_valid_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      bit_cnt_q    <= bit_cnt_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign q          = q_q;
  assign bit_cnt    = bit_cnt_q;
  assign word_valid = word_valid_q;

  // The bit the next shift will push out, so cascaded instances can chain.
  assign sdo = (mode == MODE_RIGHT) ? q_q[0] : q_q[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_reg_universal
//  Purpose  : Directed self-checking bench for shift_reg_universal, WIDTH=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_universal;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [1:0]       mode;
  logic             sdi;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sdo;
  logic [CNT_W-1:0] bit_cnt;
  logic             word_valid;

  int n_checks = 0;
  int n_pass   = 0;

  shift_reg_universal #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .sdi        (sdi),
    .d          (d),
    .q          (q),
    .sdo        (sdo),
    .bit_cnt    (bit_cnt),
    .word_valid (word_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic [1:0] m, input logic s);
    @(negedge clk);
    en = e; mode = m; sdi = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  bits;
    logic [15:0] stream;
    logic [7:0]  exp_q;
    int          pulses;

    reset = 1'b1; en = 1'b0; mode = 2'b00; sdi = 1'b0; d = '0;

    // ---------------- reset state ----------------
    #3;
    check("rst_q",   q, 0);
    check("rst_cnt", bit_cnt, 0);
    check("rst_wv",  word_valid, 0);
    check("rst_sdo", sdo, 0);
    @(negedge clk); reset = 1'b0;

    // ---------------- load A5, then async reset mid-cycle ----------------
    d = 8'hA5;
    step(1'b1, 2'b11, 1'b0);
    check("load_q",   q, 8'hA5);
    check("load_cnt", bit_cnt, 0);
    @(negedge clk); en = 1'b0; mode = 2'b00;
    #2 reset = 1'b1;
    #1;
    check("async_q",   q, 0);
    check("async_cnt", bit_cnt, 0);
    check("async_wv",  word_valid, 0);
    check("async_sdo", sdo, 0);
    #1 reset = 1'b0;

    // ---------------- shift-left word -> B2 ----------------
    bits = 8'b1011_0010;  // sent in order bits[7] .. bits[0]
    for (int i = 0; i < 8; i++) begin
      check("sl_cnt_pre", bit_cnt, i);
      step(1'b1, 2'b01, bits[7-i]);
      check("sl_wv", word_valid, (i == 7) ? 1 : 0);
    end
    check("sl_q",   q, 8'hB2);
    check("sl_cnt", bit_cnt, 0);
    check("sl_sdo", sdo, 1);            // mode 01 -> q[7]
    step(1'b0, 2'b01, 1'b1);            // en low: hold after the pulse
    check("hold_en_wv",  word_valid, 0);
    check("hold_en_q",   q, 8'hB2);
    check("hold_en_cnt", bit_cnt, 0);
    step(1'b1, 2'b00, 1'b1);            // mode 00
    check("hold_m0_q", q, 8'hB2);

    // ---------------- shift-right word -> 4D ----------------
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b10, bits[7-i]);
      check("sr_wv", word_valid, (i == 7) ? 1 : 0);
    end
    check("sr_q", q, 8'h4D);
    check("sr_sdo_right", sdo, 1);      // mode still 10 -> q[0]
    @(negedge clk); en = 1'b0; mode = 2'b01; #1;
    check("sr_sdo_left", sdo, 0);       // mode 01 -> q[7]
    step(1'b0, 2'b00, 1'b0);
    check("sr_wv_drop", word_valid, 0);

    // ---------------- load aborts a partial word ----------------
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b1);
    check("ab_cnt3", bit_cnt, 3);
    d = 8'h3C;
    step(1'b1, 2'b11, 1'b0);
    check("ab_load_q",   q, 8'h3C);
    check("ab_load_cnt", bit_cnt, 0);
    check("ab_load_wv",  word_valid, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b01, 1'b1);
      check("ab_wv", word_valid, (i == 7) ? 1 : 0);
    end
    check("ab_q", q, 8'hFF);

    // ---------------- enable gap + back-to-back words 96, 69 ----------------
    stream = 16'h9669;
    exp_q  = 8'hFF;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'b01, stream[15-i]);
      exp_q = {exp_q[6:0], stream[15-i]};
      if (word_valid) pulses++;
      check("bb_q",   q, exp_q);
      check("bb_cnt", bit_cnt, (i + 1) % 8);
      check("bb_wv",  word_valid, (i == 7 || i == 15) ? 1 : 0);
      if (i == 7)  check("bb_word0", q, 8'h96);
      if (i == 15) check("bb_word1", q, 8'h69);
      if (i == 4) begin
        for (int g = 0; g < 2; g++) begin
          step(1'b0, 2'b01, ~stream[15-i]);
          check("gap_q",   q, exp_q);
          check("gap_cnt", bit_cnt, 5);
          check("gap_wv",  word_valid, 0);
        end
      end
    end
    check("bb_pulses", pulses, 2);

    // ---------------- reset mid-word ----------------
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b1);
    check("rm_cnt5", bit_cnt, 5);
    @(negedge clk); en = 1'b0; mode = 2'b00;
    #2 reset = 1'b1;
    #1;
    check("rm_cnt", bit_cnt, 0);
    check("rm_q",   q, 0);
    #1 reset = 1'b0;
    bits   = 8'hC3;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b01, bits[7-i]);
      if (word_valid) pulses++;
      check("rm_wv", word_valid, (i == 7) ? 1 : 0);
    end
    check("rm_q_word", q, 8'hC3);
    check("rm_pulses", pulses, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
